tm1638_key_reader: RTL and testbench
====================================

// Module: tm1638_key_reader
// PURPOSE
//  Reads the 8 push keys of a TM1638 LED&KEY board. Issues the TM1638 read-key command
//  (0x42) on STB/CLK/DIO, reads the 4 key-scan bytes, decodes S1..S8, debounces and
//  reports stable state plus press/release pulses. Shares the TM1638 bus with the
//  LED/7-seg writer through a REQ/GNT handshake, and sits next to that writer in the top.
// PARAMETERS
//  C_FCK       48_000_000  system clock frequency [Hz]
//  C_FSCLK     500_000     serial clock frequency [Hz]; C_HALF = C_FCK/(2*C_FSCLK) CK cycles (>=4)
//  C_FSCAN     100         frame start rate [Hz]; C_SCAN_P = C_FCK/C_FSCAN CK cycles
//  C_TWAIT_US  2           gap between command byte and first read bit [us]
//  C_DEB_N     3           consecutive identical scans needed to accept a new key vector (1..15)
// PORTS
//  CK_i           in   1   system clock, all logic on posedge
//  XARST_i        in   1   asynchronous active-low reset
//  EN_i           in   1   1 = periodic scanning enabled
//  BUS_REQ_o      out  1   bus request to the TM1638 bus owner/arbiter
//  BUS_GNT_i      in   1   bus grant; must stay 1 while BUS_REQ_o=1
//  STB_o          out  1   TM1638 STB, active low
//  SCLK_o         out  1   TM1638 CLK, idles high
//  DIO_o          out  1   TM1638 DIO output data
//  DIO_OE_o       out  1   1 = drive DIO_o on the pad, 0 = release (pad pulled up)
//  DIO_i          in   1   TM1638 DIO pad input (asynchronous)
//  RAW_o          out  32  last frame's key-scan bytes {byte3,byte2,byte1,byte0}
//  KEY_o          out  8   debounced key state, bit n = S(n+1), 1 = pressed
//  KEY_PRESS_o    out  8   1-CK pulse per key going 0->1 in KEY_o
//  KEY_RELEASE_o  out  8   1-CK pulse per key going 1->0 in KEY_o
//  SCAN_DONE_o    out  1   1-CK pulse at the end of every frame
// BEHAVIOUR
//  Reset: STB_o=1, SCLK_o=1, DIO_o=1, DIO_OE_o=0, BUS_REQ_o=0, RAW_o=0, KEY_o=0,
//   all pulses 0, scan timer=0, debounce count=0, FSM=IDLE. Reset mid-frame aborts it.
//  Scan timer: free-running mod C_SCAN_P; its wrap with EN_i=1 sets a start flag.
//   If a frame is still running at wrap, the flag is held; no queueing beyond one frame.
//  FSM:
//   IDLE  : if start flag -> REQ, BUS_REQ_o=1.
//   REQ   : wait BUS_GNT_i=1 (sampled here only) -> SETUP; STB_o=0, DIO_OE_o=1.
//   SETUP : hold C_HALF cycles -> CMD.
//   CMD   : 8 bits of 0x42, LSB first. Per bit: SCLK_o=0 for C_HALF with DIO_o=bit,
//           then SCLK_o=1 for C_HALF. After bit 7 -> WAIT with DIO_OE_o=0.
//   WAIT  : SCLK_o=1, hold C_TWAIT_US*C_FCK/1e6 cycles (min C_HALF) -> RD.
//   RD    : 32 bits, LSB first. Per bit: SCLK_o=0 for C_HALF, then 1 for C_HALF.
//           DIO_i goes through a 2-FF synchronizer; bit is sampled on the last CK of
//           the SCLK high half. After bit 31 -> HOLD.
//   HOLD  : STB_o=0 for C_HALF -> END. END: STB_o=1, BUS_REQ_o=0, RAW_o updated,
//           SCAN_DONE_o=1 for 1 CK, debounce evaluated -> IDLE.
//  EN_i=0 mid-frame: frame completes normally; no new frames start.
//  Decode: K[n]=RAW[8n] for n=0..3, K[n+4]=RAW[8n+4] for n=0..3 (byte n bit0/bit4).
//  Debounce, evaluated at END: if K==previous K, count++ (saturating at C_DEB_N),
//   else count=1 and previous K=K. When count reaches C_DEB_N and K!=KEY_o:
//   KEY_o<=K, KEY_PRESS_o=K&~KEY_o, KEY_RELEASE_o=~K&KEY_o, pulses 1 CK, same
//   cycle as SCAN_DONE_o. Simultaneous changes on several keys are reported together.
//  Frame length: C_HALF*(1+16+64+1) + WAIT + handshake cycles.
// TESTING
//  1 Reset then EN_i=1, GNT tied 1: STB falls, CLK shows 8 pulses carrying 0x42
//    LSB-first (0,1,0,0,0,0,1,0), DIO_OE_o drops after bit 7, 32 read pulses follow.
//  2 Device model returns bytes 0x01,0x10,0x00,0x01: RAW_o=0x01_00_10_01,
//    after 3 identical frames KEY_o=8'h29 and KEY_PRESS_o=8'h29 for exactly 1 CK.
//  3 Key S1 bounces (alternating RAW bit0 per frame) for 5 frames, then stable 1:
//    KEY_o[0] changes only on the 3rd stable frame; no pulse during bouncing.
//  4 GNT held 0 for 1000 CK after REQ: STB_o stays 1, no CLK activity;
//    frame starts C_HALF after GNT=1.
//  5 XARST_i pulsed low during RD bit 12: outputs at reset values immediately
//    (async), next frame restarts from IDLE with command 0x42.
//  6 EN_i=0 during CMD: current frame ends with SCAN_DONE_o; no further STB fall.

Source files
------------

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: periodically issues read-key (0x42), shifts in 4 scan bytes,
// decodes S1..S8 and debounces them. Bus access is arbitrated through BUS_REQ_o/BUS_GNT_i.
module tm1638_key_reader #(
    parameter int C_FCK      = 48_000_000,
    parameter int C_FSCLK    = 500_000,
    parameter int C_FSCAN    = 100,
    parameter int C_TWAIT_US = 2,
    parameter int C_DEB_N    = 3
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic        EN_i,
    output logic        BUS_REQ_o,
    input  logic        BUS_GNT_i,
    output logic        STB_o,
    output logic        SCLK_o,
    output logic        DIO_o,
    output logic        DIO_OE_o,
    input  logic        DIO_i,
    output logic [31:0] RAW_o,
    output logic [7:0]  KEY_o,
    output logic [7:0]  KEY_PRESS_o,
    output logic [7:0]  KEY_RELEASE_o,
    output logic        SCAN_DONE_o
);
    localparam int C_HALF   = C_FCK / (2 * C_FSCLK);
    localparam int C_SCAN_P = C_FCK / C_FSCAN;
    localparam int C_TW_RAW = int'((longint'(C_TWAIT_US) * longint'(C_FCK)) / 64'd1_000_000);
    localparam int C_WAIT   = (C_TW_RAW < C_HALF) ? C_HALF : C_TW_RAW;
    localparam int CW       = $clog2(C_WAIT + 1);
    localparam int SW       = $clog2(C_SCAN_P);
    localparam int DW       = $clog2(C_DEB_N + 1);
    localparam logic [7:0] CMD_RDKEY = 8'h42;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SETUP, S_CMD, S_WAIT, S_RD, S_HOLD, S_END
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     sh_q, sh_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic            start_q, start_d;
    logic [1:0]      sync_q, sync_d;
    logic [31:0]     raw_q, raw_d;
    logic [7:0]      key_q, key_d, press_q, press_d, release_q, release_d;
    logic [7:0]      prev_k_q, prev_k_d, k_new;
    logic [DW-1:0]   deb_q, deb_d;
    logic            half_end, last_bit, start_clr, wrap, eval;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            bit_q     <= '0;
            sh_q      <= '0;
            scan_q    <= '0;
            start_q   <= 1'b0;
            sync_q    <= 2'b11;
            raw_q     <= '0;
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            prev_k_q  <= '0;
            deb_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            scan_q    <= scan_d;
            start_q   <= start_d;
            sync_q    <= sync_d;
            raw_q     <= raw_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            prev_k_q  <= prev_k_d;
            deb_q     <= deb_d;
        end
    end

    assign half_end = (cnt_q == CW'(C_HALF - 1));
    assign last_bit = (state_q == S_CMD) ? (bit_q == 5'd7) : (bit_q == 5'd31);

    // Next-state: shared half-period timer drives both the command and read shifts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        phase_d   = phase_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        start_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_q) begin
                    state_d   = S_REQ;
                    start_clr = 1'b1;
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (BUS_GNT_i) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (half_end) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD, S_RD: begin
                if (half_end) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (state_q == S_RD) sh_d = {sync_q[1], sh_q[31:1]};
                        if (last_bit) begin
                            bit_d   = '0;
                            state_d = (state_q == S_CMD) ? S_WAIT : S_HOLD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(C_WAIT - 1)) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    state_d = S_RD;
                end
            end
            S_HOLD: begin
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = S_END;
                end
            end
            S_END: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan timer, start flag and DIO synchronizer.
    always_comb begin
        wrap    = (scan_q == SW'(C_SCAN_P - 1));
        scan_d  = wrap ? '0 : scan_q + SW'(1);
        start_d = EN_i & ((start_q & ~start_clr) | wrap);
        sync_d  = {sync_q[0], DIO_i};
    end

    always_comb begin
        k_new = '0;
        for (int n = 0; n < 4; n++) begin
            k_new[n]     = sh_q[8*n];
            k_new[n + 4] = sh_q[8*n + 4];
        end
    end

    // Debounce is evaluated as HOLD ends so results and pulses land in the END cycle.
    always_comb begin
        eval      = (state_q == S_HOLD) && half_end;
        raw_d     = raw_q;
        key_d     = key_q;
        press_d   = '0;
        release_d = '0;
        prev_k_d  = prev_k_q;
        deb_d     = deb_q;
        if (eval) begin
            raw_d = sh_q;
            if (k_new == prev_k_q) begin
                deb_d = (deb_q >= DW'(C_DEB_N)) ? deb_q : deb_q + DW'(1);
            end else begin
                deb_d    = DW'(1);
                prev_k_d = k_new;
            end
            if (deb_d == DW'(C_DEB_N) && k_new != key_q) begin
                key_d     = k_new;
                press_d   = k_new & ~key_q;
                release_d = ~k_new & key_q;
            end
        end
    end

    always_comb begin
        STB_o     = 1'b0;
        SCLK_o    = 1'b1;
        DIO_o     = 1'b1;
        DIO_OE_o  = 1'b0;
        BUS_REQ_o = 1'b1;
        case (state_q)
            S_IDLE, S_END: begin
                STB_o     = 1'b1;
                BUS_REQ_o = 1'b0;
            end
            S_REQ:   STB_o = 1'b1;
            S_SETUP: DIO_OE_o = 1'b1;
            S_CMD: begin
                DIO_OE_o = 1'b1;
                DIO_o    = CMD_RDKEY[bit_q[2:0]];
                SCLK_o   = phase_q;
            end
            S_RD:    SCLK_o = phase_q;
            default: ;
        endcase
    end

    assign SCAN_DONE_o   = (state_q == S_END);
    assign RAW_o         = raw_q;
    assign KEY_o         = key_q;
    assign KEY_PRESS_o   = press_q;
    assign KEY_RELEASE_o = release_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a behavioural TM1638 key-scan responder.
module tb_tm1638_key_reader;
    localparam int HALF   = 4;
    localparam int SCAN_P = 800;

    logic        clk, rst_n, en, gnt, dio_in;
    logic        req, stb, sclk, dio, dio_oe, done;
    logic [31:0] raw;
    logic [7:0]  key, press, rel;

    tm1638_key_reader #(
        .C_FCK(8_000_000), .C_FSCLK(1_000_000), .C_FSCAN(10_000),
        .C_TWAIT_US(2), .C_DEB_N(3)
    ) dut (
        .CK_i(clk), .XARST_i(rst_n), .EN_i(en), .BUS_REQ_o(req), .BUS_GNT_i(gnt),
        .STB_o(stb), .SCLK_o(sclk), .DIO_o(dio), .DIO_OE_o(dio_oe), .DIO_i(dio_in),
        .RAW_o(raw), .KEY_o(key), .KEY_PRESS_o(press), .KEY_RELEASE_o(rel),
        .SCAN_DONE_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Device model: captures the command on SCLK rises, drives read bits after SCLK falls.
    logic [31:0] resp;
    logic [7:0]  cmd_cap = '0;
    int          cmd_edges = 0, rd_bits = 0, oe_err = 0, stb_falls = 0;
    logic        sclk_prev = 1'b1, stb_prev = 1'b1;

    always @(negedge clk) begin
        if (stb_prev === 1'b1 && stb === 1'b0) begin
            stb_falls++;
            cmd_edges = 0;
            rd_bits   = 0;
            oe_err    = 0;
            cmd_cap   = '0;
        end
        if (stb !== 1'b0) begin
            dio_in = 1'b1;
        end else if (sclk_prev === 1'b0 && sclk === 1'b1 && cmd_edges < 8) begin
            cmd_cap[cmd_edges] = dio & dio_oe;
            cmd_edges++;
        end else if (sclk_prev === 1'b1 && sclk === 1'b0 && cmd_edges == 8) begin
            if (dio_oe) oe_err++;
            if (rd_bits < 32) dio_in = resp[rd_bits];
            rd_bits++;
        end
        sclk_prev = sclk;
        stb_prev  = stb;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic chk_frame(input string nm, input logic [31:0] exp_raw);
        chk({nm, "_cmd"}, {24'h0, cmd_cap}, 32'h42);
        chk({nm, "_rdbits"}, rd_bits, 32);
        chk({nm, "_oe_during_rd"}, oe_err, 0);
        chk({nm, "_raw"}, raw, exp_raw);
    endtask

    typedef struct {
        logic [31:0] resp;
        logic [7:0]  key;
        logic [7:0]  press;
        logic [7:0]  rel;
    } vec_t;

    vec_t tbl[21];

    initial begin
        bit ok;
        int n, i, f0, bad;

        tbl[0]  = '{32'h01001001, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{32'h01001001, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{32'h01001001, 8'h29, 8'h29, 8'h00};
        tbl[3]  = '{32'h01001001, 8'h29, 8'h00, 8'h00};
        tbl[4]  = '{32'h00000000, 8'h29, 8'h00, 8'h00};
        tbl[5]  = '{32'h00000000, 8'h29, 8'h00, 8'h00};
        tbl[6]  = '{32'h00000000, 8'h00, 8'h00, 8'h29};
        tbl[7]  = '{32'h00000001, 8'h00, 8'h00, 8'h00};
        tbl[8]  = '{32'h00000000, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{32'h00000001, 8'h00, 8'h00, 8'h00};
        tbl[10] = '{32'h00000000, 8'h00, 8'h00, 8'h00};
        tbl[11] = '{32'h00000000, 8'h00, 8'h00, 8'h00};
        tbl[12] = '{32'h00000001, 8'h00, 8'h00, 8'h00};
        tbl[13] = '{32'h00000001, 8'h00, 8'h00, 8'h00};
        tbl[14] = '{32'h00000001, 8'h01, 8'h01, 8'h00};
        tbl[15] = '{32'h01100011, 8'h01, 8'h00, 8'h00};
        tbl[16] = '{32'h01100011, 8'h01, 8'h00, 8'h00};
        tbl[17] = '{32'h01100011, 8'h59, 8'h58, 8'h00};
        tbl[18] = '{32'hEEEEEEEE, 8'h59, 8'h00, 8'h00};
        tbl[19] = '{32'hEEEEEEEE, 8'h59, 8'h00, 8'h00};
        tbl[20] = '{32'hEEEEEEEE, 8'h00, 8'h00, 8'h59};

        rst_n = 1'b0; en = 1'b0; gnt = 1'b1; resp = '0;
        repeat (3) @(negedge clk);
        chk("rst_stb", stb, 1); chk("rst_sclk", sclk, 1); chk("rst_dio", dio, 1);
        chk("rst_oe", dio_oe, 0); chk("rst_req", req, 0); chk("rst_raw", raw, 0);
        chk("rst_key", key, 0); chk("rst_press", press, 0); chk("rst_rel", rel, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1; en = 1'b1;

        foreach (tbl[k]) begin
            resp = tbl[k].resp;
            wait_done(ok);
            chk($sformatf("v%0d_done", k), ok, 1);
            if (ok) begin
                chk_frame($sformatf("v%0d", k), tbl[k].resp);
                chk($sformatf("v%0d_key", k), key, tbl[k].key);
                chk($sformatf("v%0d_press", k), press, tbl[k].press);
                chk($sformatf("v%0d_rel", k), rel, tbl[k].rel);
                @(negedge clk);
                chk($sformatf("v%0d_press_1ck", k), press, 0);
                chk($sformatf("v%0d_rel_1ck", k), rel, 0);
            end
        end

        // Grant withheld: bus must stay quiet until grant, then STB falls a half before CLK.
        gnt = 1'b0; resp = '0;
        ok = 1'b0;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req) begin ok = 1'b1; break; end
        end
        chk("gnt_req_seen", ok, 1);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!stb || !sclk) bad++;
        end
        chk("gnt_hold_quiet", bad, 0);
        chk("gnt_req_held", req, 1);
        gnt = 1'b1;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!stb) break;
        end
        chk("gnt_stb_latency", i, 0);
        n = 1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (sclk) n++;
            else break;
        end
        chk("gnt_setup_len", n, HALF);
        wait_done(ok);
        chk("gnt_done", ok, 1);
        chk_frame("gnt", 32'h0);

        // Async reset in the middle of read bit 12.
        resp = 32'h01001001;
        repeat (3) wait_done(ok);
        chk("prerst_key", key, 8'h29);
        ok = 1'b0;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!stb && rd_bits == 13) begin ok = 1'b1; break; end
        end
        chk("rst_rd12_reached", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stb", stb, 1); chk("arst_sclk", sclk, 1); chk("arst_oe", dio_oe, 0);
        chk("arst_req", req, 0); chk("arst_raw", raw, 0); chk("arst_key", key, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(ok);
        chk("postrst_done", ok, 1);
        chk_frame("postrst", 32'h01001001);
        chk("postrst_key", key, 0);

        // EN dropped during the command byte: frame completes, nothing follows.
        ok = 1'b0;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!stb && cmd_edges == 2) begin ok = 1'b1; break; end
        end
        chk("en_cmd_reached", ok, 1);
        en = 1'b0;
        wait_done(ok);
        chk("en_done", ok, 1);
        chk_frame("en", 32'h01001001);
        f0 = stb_falls;
        repeat (2 * SCAN_P + 200) @(negedge clk);
        chk("en_no_new_frame", stb_falls, f0);
        chk("en_req_low", req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
